// File: rtl/issue_unit.sv
// issue_unit: round-robin issue arbiter from reservation stations to ALU/BTU/MULT/LSU classes.
// Define ISSUE_MULT_PIPELINED_EN to treat the multiplier as fully pipelined (no busy pacing).
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module issue_unit #(
   parameter int NUM_RS   = 4,
   parameter int MULT_LAT = 4
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic [NUM_RS-1:0]                          rs_valid,
   input  logic [NUM_RS-1:0][`ROB_TAG_LEN-1:0]        rs_tag,
   input  logic [NUM_RS-1:0][1:0]                     rs_fu,
   input  logic [3:0]                                 fu_stall,
   output logic [NUM_RS-1:0]                          clear,
   output logic [NUM_RS-1:0][`ROB_TAG_LEN-1:0]        clear_tag,
   output logic [3:0]                                 issue_valid,
   output logic [3:0][$clog2(NUM_RS)-1:0]             issue_rs,
   output logic [3:0][`ROB_TAG_LEN-1:0]               issue_tag,
   output logic                                       mult_busy
);
   localparam int RW = $clog2(NUM_RS);
   localparam int TL = `ROB_TAG_LEN;

   logic [3:0][RW-1:0] rr_ptr;
   logic [3:0]         elig;
   logic [3:0]         gnt_v;
   logic [3:0][RW-1:0] gnt_rs;
   logic [3:0][TL-1:0] gnt_tag;

   function automatic logic [RW-1:0] wrap(input logic [RW-1:0] p, input int o);
      int s = int'(p) + o;
      return RW'(s >= NUM_RS ? s - NUM_RS : s);
   endfunction

   // Reset gates eligibility so clear stays low while reset is held.
   assign elig = ~fu_stall & {1'b1, ~mult_busy, 2'b11} & {4{~reset}};

   // Descending offset scan: the requester closest to the pointer is written last and wins.
   always_comb begin
      gnt_v = '0;
      gnt_rs = '0;
      gnt_tag = '0;
      clear = '0;
      clear_tag = '0;
      for (int j = 0; j < 4; j++)
         for (int o = NUM_RS - 1; o >= 0; o--)
            if (elig[j] && rs_valid[wrap(rr_ptr[j], o)] && rs_fu[wrap(rr_ptr[j], o)] == 2'(j)) begin
               gnt_v[j] = 1'b1;
               gnt_rs[j] = wrap(rr_ptr[j], o);
            end
      for (int j = 0; j < 4; j++)
         if (gnt_v[j]) begin
            gnt_tag[j] = rs_tag[gnt_rs[j]];
            clear[gnt_rs[j]] = 1'b1;
            clear_tag[gnt_rs[j]] = rs_tag[gnt_rs[j]];
         end
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rr_ptr <= '0;
         issue_valid <= '0;
         issue_rs <= '0;
         issue_tag <= '0;
      end else begin
         for (int j = 0; j < 4; j++)
            if (gnt_v[j]) rr_ptr[j] <= wrap(gnt_rs[j], 1);
         issue_valid <= gnt_v;
         issue_rs <= gnt_rs;
         issue_tag <= gnt_tag;
      end

`ifdef ISSUE_MULT_PIPELINED_EN
   assign mult_busy = 1'b0;
`else
   logic [3:0] mult_cnt;

   always_ff @(posedge clk or posedge reset)
      if (reset) mult_cnt <= '0;
      else mult_cnt <= gnt_v[2] ? 4'(MULT_LAT - 1) : mult_cnt - 4'(mult_busy);

   assign mult_busy = |mult_cnt;
`endif
endmodule

// File: tb/tb_issue_unit.sv
// tb_issue_unit: directed plus random stimulus against a queue-based round-robin reference model.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module tb_issue_unit;
   localparam int N   = 4;
   localparam int LAT = 4;
   localparam int RW  = $clog2(N);
   localparam int TL  = `ROB_TAG_LEN;

   logic                   clk = 0;
   logic                   reset = 1;
   logic [N-1:0]           rs_valid = '0;
   logic [N-1:0][TL-1:0]   rs_tag = '0;
   logic [N-1:0][1:0]      rs_fu = '0;
   logic [3:0]             fu_stall = '0;
   logic [N-1:0]           clear;
   logic [N-1:0][TL-1:0]   clear_tag;
   logic [3:0]             issue_valid;
   logic [3:0][RW-1:0]     issue_rs;
   logic [3:0][TL-1:0]     issue_tag;
   logic                   mult_busy;

   issue_unit #(.NUM_RS(N), .MULT_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .rs_valid(rs_valid), .rs_tag(rs_tag), .rs_fu(rs_fu),
      .fu_stall(fu_stall), .clear(clear), .clear_tag(clear_tag), .issue_valid(issue_valid),
      .issue_rs(issue_rs), .issue_tag(issue_tag), .mult_busy(mult_busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]         v;
      logic [3:0][RW-1:0] rs;
      logic [3:0][TL-1:0] tag;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   vectors = 0;
   int   miscompares = 0;
   int   ptr[4] = '{0, 0, 0, 0};
   int   last_mult = -100;
   int   cyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic set_rs(input int i, input bit v, input int fu, input int tag);
      rs_valid[i] = v;
      rs_fu[i] = 2'(fu);
      rs_tag[i] = TL'(tag);
   endtask

   // Called just after a negedge with inputs already driven; checks this cycle and queues next cycle's issue.
   task automatic step();
      exp_t                 e;
      logic [N-1:0]         ec;
      logic [N-1:0][TL-1:0] ect;
      bit                   busy;
      #1;
      e = '0;
      ec = '0;
      ect = '0;
`ifdef ISSUE_MULT_PIPELINED_EN
      busy = 0;
`else
      busy = (cyc - last_mult) < LAT;
`endif
      for (int j = 0; j < 4; j++) begin
         if (fu_stall[j] || (j == 2 && busy)) continue;
         for (int o = 0; o < N; o++) begin
            int k = (ptr[j] + o) % N;
            if (rs_valid[k] && int'(rs_fu[k]) == j) begin
               e.v[j] = 1'b1;
               e.rs[j] = RW'(k);
               e.tag[j] = rs_tag[k];
               ec[k] = 1'b1;
               ect[k] = rs_tag[k];
               ptr[j] = (k + 1) % N;
               if (j == 2) last_mult = cyc;
               break;
            end
         end
      end
      chk("clear", 64'(clear), 64'(ec));
      chk("clear_tag", 64'(clear_tag), 64'(ect));
      chk("mult_busy", 64'(mult_busy), 64'(busy));
      q.push_back(e);
      cyc++;
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      #1;
      if (!reset && q.size() > 0) begin
         mon_e = q.pop_front();
         chk("issue_valid", 64'(issue_valid), 64'(mon_e.v));
         chk("issue_rs", 64'(issue_rs), 64'(mon_e.rs));
         chk("issue_tag", 64'(issue_tag), 64'(mon_e.tag));
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_issue_valid", 64'(issue_valid), 64'd0);
      chk("reset_issue_tag", 64'(issue_tag), 64'd0);
      chk("reset_mult_busy", 64'(mult_busy), 64'd0);
      chk("reset_clear", 64'(clear), 64'd0);
      reset = 0;
      // ALU sweep: tags 5..8 granted to stations 0..3 in turn
      for (int i = 0; i < N; i++) set_rs(i, 1, 0, 5 + i);
      repeat (4) step();
      // one request per class in the same cycle
      for (int i = 0; i < N; i++) set_rs(i, 1, i, 1 + i);
      step();
      rs_valid = '0;
      repeat (LAT) step();
      // back-to-back MULT requests paced by the busy counter
      set_rs(1, 1, 2, 9);
      set_rs(2, 1, 2, 10);
      step();
      set_rs(1, 0, 2, 9);
      repeat (LAT + 1) step();
      rs_valid = '0;
      // LSU stalled for three cycles then released
      set_rs(0, 1, 3, 12);
      fu_stall = 4'b1000;
      repeat (3) step();
      fu_stall = '0;
      step();
      rs_valid = '0;
      // pointer wrap: station 3 then {0,3}
      set_rs(3, 1, 0, 3);
      step();
      set_rs(0, 1, 0, 20);
      step();
      rs_valid = '0;
      repeat (LAT) step();
      // reset right after a MULT grant aborts occupancy
      set_rs(2, 1, 2, 33);
      step();
      for (int i = 0; i < N; i++) set_rs(i, 1, 0, 40 + i);
      @(posedge clk);
      #3 reset = 1;
      #1;
      chk("mid_reset_issue_valid", 64'(issue_valid), 64'd0);
      chk("mid_reset_mult_busy", 64'(mult_busy), 64'd0);
      chk("mid_reset_clear", 64'(clear), 64'd0);
      chk("mid_reset_issue_tag", 64'(issue_tag), 64'd0);
      for (int j = 0; j < 4; j++) ptr[j] = 0;
      last_mult = -100;
      q.delete();
      @(negedge clk);
      reset = 0;
      rs_valid = '0;
      set_rs(1, 1, 2, 17);
      step();
      // random traffic
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < N; i++) set_rs(i, $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, (1 << TL) - 1));
         for (int j = 0; j < 4; j++) fu_stall[j] = $urandom_range(0, 4) == 0;
         step();
      end
      rs_valid = '0;
      repeat (2) @(negedge clk);
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/issue_unit.md
# issue_unit

Per-cycle issue scheduler between the reservation stations and the four functional-unit classes (ALU, BTU, MULT, LSU). Each cycle it takes one ready candidate from each reservation station, arbitrates round-robin per FU class, drives `clear`/`clear_tag` back to the winning stations, and registers the issued tags toward the functional units. It also paces the non-pipelined multiplier with a busy counter.

## Interface
Parameters:
- `NUM_RS`, 4: number of reservation stations (requesters), 2..8.
- `MULT_LAT`, 4: multiplier occupancy in cycles, 1..15.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `rs_valid`  in  `NUM_RS`  station i presents a ready candidate.
- `rs_tag`  in  `NUM_RS` x `` `ROB_TAG_LEN``  candidate ROB tag.
- `rs_fu`  in  `NUM_RS` x 2  target class: 0=ALU, 1=BTU, 2=MULT, 3=LSU.
- `fu_stall`  in  4  FU class j cannot accept this cycle (bit index = class).
- `clear`  out  `NUM_RS`  station i was granted this cycle (combinational).
- `clear_tag`  out  `NUM_RS` x `` `ROB_TAG_LEN``  tag granted to station i; 0 when `clear[i]`=0.
- `issue_valid`  out  4  registered: class j issues this cycle.
- `issue_rs`  out  4 x `$clog2(NUM_RS)`  registered: winning station per class.
- `issue_tag`  out  4 x `` `ROB_TAG_LEN``  registered: issued tag per class.
- `mult_busy`  out  1  multiplier occupied; no MULT grant possible.

## Operation
- Request matrix: `req[j][i]` = `rs_valid[i]` && `rs_fu[i]`==j.
- Class j is eligible when `!fu_stall[j]`; MULT additionally requires `!mult_busy`.
- Per eligible class: round-robin grant among `req[j][*]`, search starting at `rr_ptr[j]`, wrapping at `NUM_RS-1` → 0. One grant per class per cycle; each station requests one class, so at most one grant per station.
- On grant of station k to class j: `clear[k]`=1, `clear_tag[k]`=`rs_tag[k]`; `rr_ptr[j]` ← (k+1) mod `NUM_RS` at next edge. No grant → pointer holds.
- Issue register: at posedge, `issue_valid[j]`/`issue_rs[j]`/`issue_tag[j]` ← grant of class j; non-granted class loads `issue_valid[j]`=0, `issue_rs`/`issue_tag`=0.
- Multiplier counter `mult_cnt` (4 bits): on MULT grant load `MULT_LAT-1`; else decrement if nonzero. `mult_busy` = (`mult_cnt`!=0). `MULT_LAT`=1 → never busy.
- Stalled or busy class: requests ignored, no `clear`, station keeps its entry and retries.

## Timing
- Reset (async, any time): `rr_ptr`=0, `mult_cnt`=0, `issue_valid`=0, `issue_rs`=0, `issue_tag`=0, `mult_busy`=0; `clear`=0 while reset is high. Reset during a multiply aborts occupancy.
- Grant latency: `clear` in cycle t (same cycle as `rs_valid`); station invalidates the entry at edge ending t; `issue_valid` high in cycle t+1.
- MULT grant in t → `mult_busy` high in t+1..t+`MULT_LAT`-1; next MULT grant possible in cycle t+`MULT_LAT`.
- `fu_stall` sampled combinationally in the same cycle as the request; must be stable before posedge.
- Simultaneous requests to different classes: all granted in the same cycle.

## Configuration
- `ISSUE_MULT_PIPELINED_EN` defined: multiplier treated as fully pipelined; `mult_cnt` removed, `mult_busy` tied 0, MULT grantable every cycle (subject to `fu_stall[2]`).
- Not defined: busy-counter pacing as described above.

## Test plan
- Reset mid-operation: grant MULT, assert `reset` in the next cycle → all outputs 0 immediately, `mult_busy`=0; MULT request after release is granted.
- `rs_valid`=4'b1111, all `rs_fu`=0 (ALU), tags 5,6,7,8 held four cycles → grants to stations 0,1,2,3 in order; `issue_tag[0]` = 5,6,7,8 one cycle later.
- Stations 0..3 target ALU, BTU, MULT, LSU at once (tags 1..4) → `clear`=4'b1111 in the same cycle; next cycle `issue_valid`=4'b1111 with matching tags.
- `MULT_LAT`=4: station 1 MULT tag 9 in t, station 2 MULT tag 10 held → tag 10 granted in t+4; `mult_busy` high in t+1..t+3; with `ISSUE_MULT_PIPELINED_EN` → tag 10 granted in t+1.
- `fu_stall[3]`=1 for 3 cycles with LSU request tag 12 → no `clear`, `issue_valid[3]`=0; grant in the cycle stall drops.
- Pointer wrap, `NUM_RS`=4: last ALU grant to station 3, then stations 0 and 3 request → station 0 wins.
